snap_reg_wide: RTL and testbench

- Parametrised snapshot bridge between a DATA_WIDTH reg_native_if slave port (from a regslv external port) and one MEM_WIDTH external memory port.
- Supports any MEM_WIDTH = N*DATA_WIDTH (N = 1..16, power of two) and any memory depth.
- Writes are staged slice-by-slice and committed atomically when slice 0 is written.
- Reads fetch the whole entry when slice 0 is read; slices 1..N-1 are then served from that snapshot. Adds an entry tag, a stale-snapshot flag and write protection.

---
 rtl/snap_reg_wide.sv | 198 +++++++++++++++++++
 tb/tb_snap_reg_wide.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snap_reg_wide.sv
// Snapshot bridge from a DATA_WIDTH register port to a MEM_WIDTH memory port.
// Define SNAP_WR_MERGE_EN to fill unstaged slices from memory (read-modify-write) on commit.
module snap_reg_wide #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    output logic                  ack_vld,
    input  logic                  ack_rdy,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  write_protect,
    output logic                  snap_stale,
    output logic                  mem_req_vld,
    input  logic                  mem_req_rdy,
    input  logic                  mem_ack_vld,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  mem_wr_data,
    input  logic [MEM_WIDTH-1:0]  mem_rd_data
);

    localparam int N          = MEM_WIDTH / DATA_WIDTH;
    localparam int SLICE_LSB  = $clog2(DATA_WIDTH / 8);
    localparam int SLICE_BITS = $clog2(N);
    localparam int SB         = (SLICE_BITS > 0) ? SLICE_BITS : 1;
    localparam int ENTRY_LSB  = SLICE_LSB + SLICE_BITS;
    localparam logic [ADDR_WIDTH-1:0] ENTRY_MASK =
        ~((ADDR_WIDTH'(1) << ENTRY_LSB) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
`ifdef SNAP_WR_MERGE_EN
        RMW_REQ,
        RMW_WAIT,
`endif
        ACK
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0][DATA_WIDTH-1:0] wr_buf;
    logic [N-1:0][DATA_WIDTH-1:0] snap;
    logic [N-1:0][DATA_WIDTH-1:0] mem_wr_data_q;
    logic [N-1:0][DATA_WIDTH-1:0] commit_word;
    logic [N-1:0][DATA_WIDTH-1:0] rd_word;
    logic [N-1:0]                 mask;
    logic [ADDR_WIDTH-1:0]        tag;
    logic                         tag_vld;
    logic [DATA_WIDTH-1:0]        rd_data_q;
    logic                         stale_q;
    logic [ADDR_WIDTH-1:0]        mem_addr_q;
    logic                         op_wr;
    logic [SB-1:0]                slice_k;
    logic [ADDR_WIDTH-1:0]        entry;
    logic                         mem_done;

    assign slice_k = SB'((addr >> SLICE_LSB) & ADDR_WIDTH'(N - 1));
    assign entry   = addr & ENTRY_MASK;
    assign rd_word = mem_rd_data;

    assign mem_done = mem_ack_vld &&
                      ((state == MEM_REQ && mem_req_rdy) || state == MEM_WAIT);

    always_comb begin
        commit_word    = wr_buf;
        commit_word[0] = wr_data;
    end

`ifdef SNAP_WR_MERGE_EN
    logic                         need_rmw;
    logic                         rmw_done;
    logic [N-1:0][DATA_WIDTH-1:0] merge_word;

    // Slice 0 always counts as staged since it arrives with the commit itself.
    assign need_rmw = ((mask | N'(1)) != {N{1'b1}});
    assign rmw_done = mem_ack_vld &&
                      ((state == RMW_REQ && mem_req_rdy) || state == RMW_WAIT);

    always_comb begin
        merge_word = mem_wr_data_q;
        for (int i = 1; i < N; i++) begin
            if (!mask[i]) merge_word[i] = rd_word[i];
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_vld) begin
                    if (wr_en) begin
                        if (slice_k != '0 || write_protect) begin
                            state_nxt = ACK;
                        end else begin
`ifdef SNAP_WR_MERGE_EN
                            state_nxt = need_rmw ? RMW_REQ : MEM_REQ;
`else
                            state_nxt = MEM_REQ;
`endif
                        end
                    end else if (rd_en && slice_k == '0) begin
                        state_nxt = MEM_REQ;
                    end else begin
                        state_nxt = ACK;
                    end
                end
            end
            MEM_REQ:  if (mem_req_rdy) state_nxt = mem_ack_vld ? ACK : MEM_WAIT;
            MEM_WAIT: if (mem_ack_vld) state_nxt = ACK;
`ifdef SNAP_WR_MERGE_EN
            RMW_REQ:  if (mem_req_rdy) state_nxt = mem_ack_vld ? MEM_REQ : RMW_WAIT;
            RMW_WAIT: if (mem_ack_vld) state_nxt = MEM_REQ;
`endif
            ACK:      if (ack_rdy) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A request with neither enable set is acknowledged without side effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_buf        <= '0;
            mask          <= '0;
            snap          <= '0;
            tag           <= '0;
            tag_vld       <= 1'b0;
            rd_data_q     <= '0;
            stale_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            op_wr         <= 1'b0;
        end else begin
            state   <= state_nxt;
            stale_q <= 1'b0;
            if (state == IDLE && req_vld) begin
                mem_addr_q <= entry;
                rd_data_q  <= '0;
                op_wr      <= wr_en;
                if (wr_en) begin
                    if (slice_k != '0) begin
                        wr_buf[slice_k] <= wr_data;
                        mask[slice_k]   <= 1'b1;
                    end else if (write_protect) begin
                        mask <= '0;
                    end else begin
                        mem_wr_data_q <= commit_word;
                    end
                end else if (rd_en && slice_k != '0) begin
                    rd_data_q <= snap[slice_k];
                    stale_q   <= !tag_vld || (tag != entry);
                end
            end
            // Commits to the snapshotted entry are mirrored so later slice reads stay coherent.
            if (mem_done) begin
                if (op_wr) begin
                    mask <= '0;
                    if (tag == mem_addr_q) snap <= mem_wr_data_q;
                end else begin
                    snap      <= rd_word;
                    tag       <= mem_addr_q;
                    tag_vld   <= 1'b1;
                    rd_data_q <= rd_word[0];
                end
            end
`ifdef SNAP_WR_MERGE_EN
            if (rmw_done) mem_wr_data_q <= merge_word;
`endif
        end
    end

    assign req_rdy     = !rst && state == IDLE;
    assign ack_vld     = !rst && state == ACK;
    assign rd_data     = rst ? '0 : rd_data_q;
    assign snap_stale  = !rst && stale_q;
`ifdef SNAP_WR_MERGE_EN
    assign mem_req_vld = !rst && (state == MEM_REQ || state == RMW_REQ);
`else
    assign mem_req_vld = !rst && state == MEM_REQ;
`endif
    assign mem_wr_en   = mem_req_vld && state == MEM_REQ && op_wr;
    assign mem_rd_en   = mem_req_vld && !(state == MEM_REQ && op_wr);
    assign mem_addr    = rst ? '0 : mem_addr_q;
    assign mem_wr_data = rst ? '0 : mem_wr_data_q;

endmodule

// File: tb/tb_snap_reg_wide.sv
// Directed bench for snap_reg_wide (N = 4): vector table plus stall and reset sequences.
// Expectations for the SNAP_WR_MERGE_EN build are selected with the same macro.
module tb_snap_reg_wide;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_vld, req_rdy, ack_vld, ack_rdy, wr_en, rd_en;
    logic [63:0]  addr;
    logic [31:0]  wr_data, rd_data;
    logic         write_protect, snap_stale;
    logic         mem_req_vld, mem_req_rdy, mem_ack_vld, mem_wr_en, mem_rd_en;
    logic [63:0]  mem_addr;
    logic [127:0] mem_wr_data, mem_rd_data;

    snap_reg_wide #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .MEM_WIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .ack_vld(ack_vld), .ack_rdy(ack_rdy),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .write_protect(write_protect), .snap_stale(snap_stale),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_ack_vld(mem_ack_vld),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] A4 = {4{32'hAAAAAAAA}};
    localparam logic [127:0] F4 = {4{32'hFFFFFFFF}};
    localparam logic [127:0] M1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] M2 = 128'h000000B3_000000B2_000000B1_000000B0;
`ifdef SNAP_WR_MERGE_EN
    localparam int           HS_C = 2;
    localparam int           LAT_C = 3;
    localparam logic [31:0]  R14 = 32'h000000B1;
    localparam logic [127:0] M13 = 128'h000000B3_000000B2_000000B1_000000D0;
    localparam logic [127:0] M26 = 128'hAAAAAAAA_12345678_AAAAAAAA_00000000;
`else
    localparam int           HS_C = 1;
    localparam int           LAT_C = 2;
    localparam logic [31:0]  R14 = 32'h000000C1;
    localparam logic [127:0] M13 = 128'h000000B3_000000B2_000000C1_000000D0;
    localparam logic [127:0] M26 = 128'hFFFFFFFF_12345678_FFFFFFFF_00000000;
`endif

    typedef struct {
        logic         wr;
        logic [63:0]  a;
        logic [31:0]  d;
        logic         wp;
        logic         poke;
        int           poke_idx;
        logic [127:0] poke_val;
        logic         chk_rd;
        logic [31:0]  exp_rd;
        int           exp_stale;
        int           exp_hs;
        int           exp_lat;
        logic         chk_mem;
        int           mem_idx;
        logic [127:0] exp_mem;
    } vec_t;

    vec_t vecs[$];

    logic [127:0] tb_mem [0:15];
    logic [127:0] resp_data;
    int           hs_count = 0;
    int           stall_left = 0;
    int           ack_lat = 0;
    int           wait_cnt = 0;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  got_rd;
    int           got_stale, got_lat, got_hs;

    // Memory responder: optional ready stall, response coincident or ack_lat cycles later.
    initial begin
        mem_req_rdy = 1'b0;
        mem_ack_vld = 1'b0;
        mem_rd_data = '0;
        resp_data   = '0;
        forever begin
            @(negedge clk);
            mem_req_rdy = 1'b0;
            mem_ack_vld = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    mem_ack_vld = 1'b1;
                    mem_rd_data = resp_data;
                end
            end else if (mem_req_vld) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_rdy = 1'b1;
                    hs_count++;
                    resp_data = tb_mem[mem_addr[7:4]];
                    if (mem_wr_en) tb_mem[mem_addr[7:4]] = mem_wr_data;
                    if (ack_lat == 0) begin
                        mem_ack_vld = 1'b1;
                        mem_rd_data = resp_data;
                    end else begin
                        wait_cnt = ack_lat;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [63:0] a, input logic [31:0] d,
                                 input logic wp, output logic [31:0] rd, output int stale_cnt,
                                 output int lat, output int hs);
        int hs0;
        hs0       = hs_count;
        stale_cnt = 0;
        lat       = 0;
        rd        = '0;
        @(negedge clk);
        req_vld = 1'b1; wr_en = wr; rd_en = !wr; addr = a; wr_data = d;
        write_protect = wp; ack_rdy = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; write_protect = 1'b0;
            end
            if (snap_stale) stale_cnt++;
            if (ack_vld) begin
                lat = i;
                rd  = rd_data;
                break;
            end
        end
        if (lat == 0) checkOutput("ack timeout", 128'(0), 128'(1));
        hs = hs_count - hs0;
    endtask

    task automatic stalledAccess(input logic wr, input logic [63:0] a, input logic [31:0] d,
                                 input logic [127:0] exp_wdata, input logic [31:0] exp_rd);
        int          vld_cyc = 0;
        int          ack_cyc = 0;
        logic        rdy_seen = 1'b0, addr_bad = 1'b0, data_bad = 1'b0;
        logic        en_bad = 1'b0, rd_bad = 1'b0, done = 1'b0;
        logic [31:0] rd_first = '0;
        stall_left = 3;
        ack_lat    = 1;
        @(negedge clk);
        req_vld = 1'b1; wr_en = wr; rd_en = !wr; addr = a; wr_data = d;
        write_protect = 1'b0; ack_rdy = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
            end
            if (req_rdy) rdy_seen = 1'b1;
            if (mem_req_vld) begin
                vld_cyc++;
                if (mem_addr !== (a & ~64'hF)) addr_bad = 1'b1;
                if (wr && mem_wr_data !== exp_wdata) data_bad = 1'b1;
                if (mem_wr_en !== wr || mem_rd_en !== !wr) en_bad = 1'b1;
            end
            if (ack_vld) begin
                if (ack_cyc == 0) rd_first = rd_data;
                else if (rd_data !== rd_first) rd_bad = 1'b1;
                ack_cyc++;
                if (ack_cyc == 6) begin
                    ack_rdy = 1'b1;
                    done    = 1'b1;
                end
            end
        end
        checkOutput("stall done", 128'(done), 128'(1));
        checkOutput("stall mem_req_vld cycles", 128'(vld_cyc), 128'(4));
        checkOutput("stall mem_addr stable", 128'(addr_bad), 128'(0));
        checkOutput("stall mem_wr_data stable", 128'(data_bad), 128'(0));
        checkOutput("stall mem enables", 128'(en_bad), 128'(0));
        checkOutput("stall req_rdy low", 128'(rdy_seen), 128'(0));
        checkOutput("stall ack_vld held", 128'(ack_cyc), 128'(6));
        checkOutput("stall rd_data stable", 128'(rd_bad), 128'(0));
        if (!wr) checkOutput("stall rd_data", 128'(rd_first), 128'(exp_rd));
        @(negedge clk);
        checkOutput("stall release req_rdy", 128'(req_rdy), 128'(1));
        checkOutput("stall release ack_vld", 128'(ack_vld), 128'(0));
        stall_left = 0;
        ack_lat    = 0;
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; ack_rdy = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wr_data = '0; write_protect = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = '0;
        tb_mem[0] = A4;
        tb_mem[1] = M1;

        // wr, addr, data, wp, poke, pidx, pval, chk_rd, exp_rd, stale, hs, lat, chk_mem, midx, exp_mem
        vecs.push_back('{1'b0, 64'h10, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'h11111111, 0, 1, 2, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h14, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'h22222222, 0, 0, 1, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h1C, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'h44444444, 0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h28, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'h33333333, 1, 0, 1, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h24, 32'hB1, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,        0, 0, 1, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h28, 32'hB2, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,        0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h2C, 32'hB3, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,        0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h20, 32'hB0, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,        0, 1, 2, 1'b1, 2, M2});
        vecs.push_back('{1'b0, 64'h18, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'h33333333, 0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h20, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'h000000B0, 0, 1, 2, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h2C, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'h000000B3, 0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h14, 32'hC1, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,        0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h10, 32'hC0, 1'b1, 1'b0, 0, '0, 1'b0, 32'h0,        0, 0, 1, 1'b1, 1, M1});
        vecs.push_back('{1'b1, 64'h20, 32'hD0, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,        0, HS_C, LAT_C, 1'b1, 2, M13});
        vecs.push_back('{1'b0, 64'h24, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, R14,          0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h3C, 32'hFFFFFFFF, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,  0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h38, 32'hFFFFFFFF, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,  0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h34, 32'hFFFFFFFF, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,  0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h30, 32'hFFFFFFFF, 1'b0, 1'b1, 3, A4, 1'b0, 32'h0,  0, 1, 2, 1'b1, 3, F4});
        vecs.push_back('{1'b0, 64'h30, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'hFFFFFFFF, 0, 1, 2, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h34, 32'h0,  1'b0, 1'b1, 3, A4, 1'b1, 32'hFFFFFFFF, 0, 0, 1, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h38, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'hFFFFFFFF, 0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h3C, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'hFFFFFFFF, 0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b0, 64'h18, 32'h0,  1'b0, 1'b0, 0, '0, 1'b1, 32'hFFFFFFFF, 1, 0, 1, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h30, 32'h0,  1'b1, 1'b0, 0, '0, 1'b0, 32'h0,        0, 0, 1, 1'b1, 3, A4});
        vecs.push_back('{1'b1, 64'h08, 32'h12345678, 1'b0, 1'b0, 0, '0, 1'b0, 32'h0,  0, 0, 0, 1'b0, 0, '0});
        vecs.push_back('{1'b1, 64'h00, 32'h0,  1'b0, 1'b0, 0, '0, 1'b0, 32'h0,        0, HS_C, 0, 1'b1, 0, M26});

        // Reset: every output held low, then ready on the first cycle out of reset.
        repeat (3) @(negedge clk);
        checkOutput("reset ctrl outputs",
                    128'({req_rdy, ack_vld, mem_req_vld, snap_stale, mem_wr_en, mem_rd_en}), 128'(0));
        checkOutput("reset rd_data", 128'(rd_data), 128'(0));
        checkOutput("reset mem_addr", 128'(mem_addr), 128'(0));
        checkOutput("reset mem_wr_data", mem_wr_data, 128'(0));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset req_rdy", 128'(req_rdy), 128'(1));
        checkOutput("post-reset ack_vld", 128'(ack_vld), 128'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].poke) tb_mem[4'(vecs[i].poke_idx)] = vecs[i].poke_val;
            applyStimulus(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].wp,
                          got_rd, got_stale, got_lat, got_hs);
            if (vecs[i].chk_rd)
                checkOutput($sformatf("v%0d rd_data", i), 128'(got_rd), 128'(vecs[i].exp_rd));
            checkOutput($sformatf("v%0d snap_stale pulses", i), 128'(got_stale), 128'(vecs[i].exp_stale));
            checkOutput($sformatf("v%0d mem handshakes", i), 128'(got_hs), 128'(vecs[i].exp_hs));
            if (vecs[i].exp_lat != 0)
                checkOutput($sformatf("v%0d ack latency", i), 128'(got_lat), 128'(vecs[i].exp_lat));
            if (vecs[i].chk_mem)
                checkOutput($sformatf("v%0d mem entry", i), tb_mem[4'(vecs[i].mem_idx)], vecs[i].exp_mem);
        end

        // Backpressure on both sides: stage entry 4 fully, then a stalled commit and read.
        applyStimulus(1'b1, 64'h4C, 32'h33, 1'b0, got_rd, got_stale, got_lat, got_hs);
        applyStimulus(1'b1, 64'h48, 32'h22, 1'b0, got_rd, got_stale, got_lat, got_hs);
        applyStimulus(1'b1, 64'h44, 32'h11, 1'b0, got_rd, got_stale, got_lat, got_hs);
        stalledAccess(1'b1, 64'h40, 32'h99, 128'h00000033_00000022_00000011_00000099, 32'h0);
        checkOutput("stall mem entry", tb_mem[4], 128'h00000033_00000022_00000011_00000099);
        stalledAccess(1'b0, 64'h40, 32'h0, '0, 32'h99);

        // Reset while a memory request is waiting for ready.
        stall_left = 5;
        @(negedge clk);
        req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = 64'h10; ack_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0; rd_en = 1'b0;
        checkOutput("midrst req pending", 128'(mem_req_vld), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst mem_req_vld", 128'(mem_req_vld), 128'(0));
        checkOutput("midrst ack_vld", 128'(ack_vld), 128'(0));
        rst = 1'b0;
        stall_left = 0;
        @(negedge clk);
        checkOutput("midrst req_rdy", 128'(req_rdy), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
